encoder8to3_serial: RTL and testbench
=====================================

# encoder8to3_serial

Sequential 8-to-3 encoder: accepts an 8-bit multi-hot request vector and emits the 3-bit index of every set bit, lowest index first, one index per output handshake. It is the inverse of the 3-to-8 one-hot decode used in the assignment datapath, turning select/request lines back into binary indices for downstream consumers. Input and output both use valid/ready handshakes so it can sit between a request source and a slower index consumer.

## Interface
- Parameters: none. Widths are fixed at 8 request lines and a 3-bit index.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request vector `a` is presented.
- in_ready  out  1  block can capture a vector; high only in IDLE.
- a  in  8  request vector; bit i set ↔ index i requested.
- out_valid  out  1  `Y` holds a valid index.
- out_ready  in  1  consumer accepts `Y` this cycle.
- Y  out  3  encoded index, binary, Y[2] MSB.
- out_last  out  1  `Y` is the final set bit of the current vector.
- cnt  out  4  number of indices still to emit, including the one on `Y` (0..8).
- zero_seen  out  1  one-cycle pulse: an all-zero vector was accepted and discarded.

## Operation
- States: IDLE, EMIT. Internal 8-bit `pending` register.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready with a≠0: pending←a, go to EMIT.
  - On in_valid & in_ready with a=0: stay in IDLE, pulse zero_seen for the next cycle, pending unchanged (0).
- EMIT:
  - in_ready=0, out_valid=1.
  - Y = index of the lowest set bit of pending.
  - cnt = popcount(pending).
  - out_last = (cnt==1).
  - On out_valid & out_ready: clear that bit (pending ← pending & ~onehot(Y)).
  - If out_last, go to IDLE with pending=0.
- While out_ready=0: Y, out_last, cnt and pending are held stable.
- Values on `a` while in_ready=0 are ignored.
- Arithmetic: cnt is 4 bits so it holds 8. Y is derived only from pending, never from `a` directly.
- Reset values: state=IDLE, pending=0, in_ready=1, out_valid=0, Y=0, out_last=0, cnt=0, zero_seen=0.

## Timing
- Capture at edge k → out_valid=1 with the first index in cycle k+1 (latency 1). Y, out_last and cnt are combinational from registered state.
- Throughput: one index per cycle while out_ready=1. A vector with n set bits occupies EMIT for exactly n cycles when there is no backpressure.
- Final handshake at edge m → IDLE and in_ready=1 in cycle m+1. The next capture is at edge m+1 at the earliest, so there is one bubble cycle between vectors.
- Reset asserted mid-EMIT: out_valid drops immediately (asynchronously) and the in-flight vector is lost. The first capture after release is on the first rising edge with rst_n=1.
- zero_seen is high for exactly one cycle after the capturing edge, and never while in EMIT.

## Structure
- Shared package encoder8to3_pkg holds:
  - Constants: N_REQ=8, IDX_W=3, CNT_W=4.
  - State enum: IDLE, EMIT.
- One sub-module, prio_enc8to3 (combinational): 8-bit input → 3-bit lowest-set-bit index plus `any` flag. The top level also computes the clear mask (onehot(Y)) and the popcount.
- Top level: FSM, pending register, handshake logic.

## Test plan
- Reset, then a=8'b1000_0001 with in_valid=1 and out_ready held at 1:
  - Y=0 with cnt=2, out_last=0.
  - Next cycle Y=7 with cnt=1, out_last=1.
  - Then IDLE, in_ready=1.
- a=8'hFF, out_ready=1: Y=0,1,…,7 on 8 consecutive cycles, cnt counting 8→1, out_last only on Y=7.
- a=8'b0010_0100 with out_ready=0 for 3 cycles, then 1:
  - Y=2 is held for 4 cycles, then Y=5.
  - in_vector change on `a` during EMIT has no effect.
- a=8'h00 accepted: zero_seen=1 for one cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back: first vector 8'h10, second 8'h02 held valid:
  - Y=4 (last).
  - One bubble cycle.
  - Y=1 (last).
- rst_n pulsed low during EMIT of 8'hF0 (after Y=4 is accepted):
  - out_valid=0 immediately, cnt=0, in_ready=1.
  - A new vector 8'h08 after release gives Y=3.

Source files
------------

// File: rtl/encoder8to3_pkg.sv
// Shared constants and state type for the serial 8-to-3 encoder.
package encoder8to3_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8to3.sv
// Combinational lowest-set-bit encoder: 8 request lines to a 3-bit index plus an any flag.
module prio_enc8to3
    import encoder8to3_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is the final assignment.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (i_req[i-1]) begin
                o_idx = IDX_W'(i - 1);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder8to3_serial.sv
// Serial 8-to-3 encoder: captures a multi-hot vector and emits each set index,
// lowest first, one per output handshake.
module encoder8to3_serial
    import encoder8to3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_REQ-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] Y,
    output logic             out_last,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_seen
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_pending;
    logic [N_REQ-1:0]   w_pending_nxt;
    logic               r_zero_seen;
    logic               w_zero_nxt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic [N_REQ-1:0]   w_clr_mask;
    logic [CNT_W-1:0]   w_cnt;

    prio_enc8to3 u_prio (
        .i_req (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_clr_mask        = '0;
        w_clr_mask[w_idx] = 1'b1;
    end

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_cnt = w_cnt + CNT_W'(r_pending[i]);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT) && w_any;
    assign Y         = w_idx;
    assign cnt       = w_cnt;
    assign out_last  = out_valid && (w_cnt == CNT_W'(1));
    assign zero_seen = r_zero_seen;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_zero_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (a != '0) begin
                        w_pending_nxt = a;
                        w_state_nxt   = EMIT;
                    end else begin
                        w_zero_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_clr_mask;
                    if (out_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_zero_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_zero_seen <= w_zero_nxt;
        end
    end

endmodule

// File: tb/tb_encoder8to3_serial.sv
// Self-checking bench for encoder8to3_serial with a queue of expected emitted indices.
module tb_encoder8to3_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] Y;
    logic       out_last;
    logic [3:0] cnt;
    logic       zero_seen;

    typedef struct packed {
        logic [2:0] y;
        logic       last;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    encoder8to3_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .out_last  (out_last),
        .cnt       (cnt),
        .zero_seen (zero_seen)
    );

    // Reference: list set bits lowest first, remaining count includes the current one.
    function automatic void push_vec(input logic [7:0] v);
        int   rem = 0;
        exp_t e;
        for (int i = 0; i < 8; i++) rem += int'(v[i]);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                e.y    = 3'(i);
                e.last = (rem == 1);
                e.cnt  = 4'(rem);
                q.push_back(e);
                rem--;
            end
        end
    endfunction

    // Present v for one accepted cycle; returns at the negedge after the capture edge.
    task automatic capture(input logic [7:0] v);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL capture_wait: in_ready=%b required 1", in_ready);
        end
        a        = v;
        in_valid = 1'b1;
        push_vec(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Y !== 3'd0 ||
            out_last !== 1'b0 || cnt !== 4'd0 || zero_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b Y=%0d last=%b cnt=%0d zs=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, Y, out_last, cnt, zero_seen);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream(input logic [7:0] v);
        exp_t e;
        out_ready = 1'b1;
        capture(v);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Y !== e.y ||
                out_last !== e.last || cnt !== e.cnt) begin
                errors++;
                $display("FAIL stream_%h: valid=%b rdy=%b Y=%0d last=%b cnt=%0d required 1 0 %0d %b %0d",
                         v, out_valid, in_ready, Y, out_last, cnt, e.y, e.last, e.cnt);
            end
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || cnt !== 4'd0) begin
            errors++;
            $display("FAIL stream_%h_idle: in_ready=%b out_valid=%b cnt=%0d required 1 0 0",
                     v, in_ready, out_valid, cnt);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc = 0;
        out_ready = 1'b0;
        capture(8'b0010_0100);
        a        = 8'hFF;
        in_valid = 1'b1;
        while (q.size() > 0 && cyc < 20) begin
            out_ready = (cyc >= 3);
            e = q[0];
            if (e.last) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || Y !== e.y || out_last !== e.last || cnt !== e.cnt) begin
                errors++;
                $display("FAIL backpressure_c%0d: valid=%b Y=%0d last=%b cnt=%0d required 1 %0d %b %0d",
                         cyc, out_valid, Y, out_last, cnt, e.y, e.last, e.cnt);
            end
            if (out_ready) void'(q.pop_front());
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (cyc != 5 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: cycles=%0d in_ready=%b out_valid=%b required 5 1 0",
                     cyc, in_ready, out_valid);
        end
        q.delete();
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        capture(8'h00);
        checks++;
        if (zero_seen !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse: zs=%b out_valid=%b in_ready=%b required 1 0 1",
                     zero_seen, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (zero_seen !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: zs=%b out_valid=%b required 0 0", zero_seen, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        capture(8'h10);
        a        = 8'h02;
        in_valid = 1'b1;
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || Y !== e.y || out_last !== e.last || zero_seen !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid=%b Y=%0d last=%b zs=%b required 1 %0d %b 0",
                     out_valid, Y, out_last, zero_seen, e.y, e.last);
        end
        push_vec(8'h02);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bubble: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || Y !== e.y || out_last !== e.last || cnt !== e.cnt) begin
            errors++;
            $display("FAIL b2b_second: valid=%b Y=%0d last=%b cnt=%0d required 1 %0d %b %0d",
                     out_valid, Y, out_last, cnt, e.y, e.last, e.cnt);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_ready = 1'b1;
        capture(8'hF0);
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || Y !== e.y || cnt !== e.cnt) begin
            errors++;
            $display("FAIL rstmid_first: valid=%b Y=%0d cnt=%0d required 1 %0d %0d",
                     out_valid, Y, cnt, e.y, e.cnt);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || cnt !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: out_valid=%b cnt=%0d in_ready=%b required 0 0 1",
                     out_valid, cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(8'h08);
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || Y !== e.y || out_last !== e.last || cnt !== e.cnt) begin
            errors++;
            $display("FAIL rstmid_after: valid=%b Y=%0d last=%b cnt=%0d required 1 %0d %b %0d",
                     out_valid, Y, out_last, cnt, e.y, e.last, e.cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream(8'b1000_0001);
        test_stream(8'hFF);
        test_stream(8'b0101_1010);
        test_backpressure();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        for (int k = 0; k < 6; k++) test_stream(8'($urandom_range(1, 255)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
